// File: rtl/gshare_predictor_if.sv
// Fetch-side prediction and resolve-side update bundle for the gshare predictor.
// The master drives the fetch/resolve inputs; the slave is the predictor.
interface gshare_if #(
  parameter int IDX_W      = 8,
  parameter int GHR_WIDTH  = 8,
  parameter int PERF_WIDTH = 32
);
  logic                  pred_valid;
  logic [31:0]           pred_pc;
  logic                  stall;
  logic                  pred_taken;
  logic [IDX_W-1:0]      pred_idx;
  logic [GHR_WIDTH-1:0]  pred_ghr;
  logic                  upd_valid;
  logic [IDX_W-1:0]      upd_idx;
  logic [GHR_WIDTH-1:0]  upd_ghr;
  logic                  upd_taken;
  logic                  upd_mispredict;
  logic [PERF_WIDTH-1:0] perf_pred;
  logic [PERF_WIDTH-1:0] perf_miss;

  modport master (
    output pred_valid, pred_pc, stall,
    output upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
    input  pred_taken, pred_idx, pred_ghr, perf_pred, perf_miss
  );

  modport slave (
    input  pred_valid, pred_pc, stall,
    input  upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
    output pred_taken, pred_idx, pred_ghr, perf_pred, perf_miss
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch predictor: PC xor speculative global history indexes a
// table of saturating counters; history is restored from a per-branch snapshot on mispredict.
module gshare_predictor #(
  parameter int ENTRIES    = 256,
  parameter int GHR_WIDTH  = 8,
  parameter int CNT_WIDTH  = 2,
  parameter int PC_LSB     = 2,
  parameter int PERF_WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  gshare_if.slave io_bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_WIDTH-1:0] CNT_RST = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

  function automatic logic [CNT_WIDTH-1:0] cnt_train(input logic [CNT_WIDTH-1:0] c,
                                                     input logic taken);
    if (taken) return (&c) ? c : c + CNT_WIDTH'(1);
    else       return (c == '0) ? c : c - CNT_WIDTH'(1);
  endfunction

  function automatic logic [PERF_WIDTH-1:0] perf_sat_inc(input logic [PERF_WIDTH-1:0] v);
    return (&v) ? v : v + PERF_WIDTH'(1);
  endfunction

  // Shifting through a one-wider concatenation keeps GHR_WIDTH=1 legal without a special case.
  function automatic logic [GHR_WIDTH-1:0] ghr_push(input logic [GHR_WIDTH-1:0] h,
                                                    input logic b);
    logic [GHR_WIDTH:0] w_cat;
    w_cat = {h, b};
    return w_cat[GHR_WIDTH-1:0];
  endfunction

  logic [GHR_WIDTH-1:0]  r_ghr;
  logic [CNT_WIDTH-1:0]  r_tbl [ENTRIES];
  logic [PERF_WIDTH-1:0] r_perf_pred;
  logic [PERF_WIDTH-1:0] r_perf_miss;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_taken;
  logic                  w_recover;
  logic                  w_shift;
  logic                  w_unused_pc;

  assign w_idx       = io_bus.pred_pc[PC_LSB +: IDX_W] ^ IDX_W'(r_ghr);
  assign w_taken     = r_tbl[w_idx][CNT_WIDTH-1];
  assign w_recover   = io_bus.upd_valid & io_bus.upd_mispredict;
  assign w_shift     = io_bus.pred_valid & ~io_bus.stall;
  assign w_unused_pc = ^io_bus.pred_pc;

  assign io_bus.pred_taken = w_taken;
  assign io_bus.pred_idx   = w_idx;
  assign io_bus.pred_ghr   = r_ghr;
  assign io_bus.perf_pred  = r_perf_pred;
  assign io_bus.perf_miss  = r_perf_miss;

  // Recovery wins over a same-cycle speculative shift: that fetch is being flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_recover) begin
      r_ghr <= ghr_push(io_bus.upd_ghr, io_bus.upd_taken);
    end else if (w_shift) begin
      r_ghr <= ghr_push(r_ghr, w_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= CNT_RST;
    end else if (io_bus.upd_valid) begin
      r_tbl[io_bus.upd_idx] <= cnt_train(r_tbl[io_bus.upd_idx], io_bus.upd_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_pred <= '0;
      r_perf_miss <= '0;
    end else begin
      if (w_shift && !w_recover) r_perf_pred <= perf_sat_inc(r_perf_pred);
      if (w_recover)             r_perf_miss <= perf_sat_inc(r_perf_miss);
    end
  end
endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor with 16 entries, 4-bit history, 2-bit counters, 4-bit perf counters.
module tb_gshare_predictor;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int GHR_W   = 4;
  localparam int PERF_W  = 4;

  typedef struct {
    logic [31:0] pc;
    logic        pv, st, uv, um, ut;
    logic [3:0]  uidx, ughr;
    logic        et;
    logic [3:0]  ei, eg, epp, epm;
  } vec_t;

  typedef struct {
    logic       et;
    logic [3:0] ei, eg, epp, epm;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];
  exp_t exp_q[$];

  gshare_if #(.IDX_W(IDX_W), .GHR_WIDTH(GHR_W), .PERF_WIDTH(PERF_W)) bus ();

  gshare_predictor #(
    .ENTRIES(ENTRIES), .GHR_WIDTH(GHR_W), .CNT_WIDTH(2), .PC_LSB(2), .PERF_WIDTH(PERF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input int pc, pv, st, uv, um, ut, uidx, ughr,
                              input int et, ei, eg, pp, pm);
    vec_t v;
    v.pc   = 32'(pc);
    v.pv   = pv[0];   v.st = st[0];   v.uv = uv[0];
    v.um   = um[0];   v.ut = ut[0];
    v.uidx = uidx[3:0]; v.ughr = ughr[3:0];
    v.et   = et[0];
    v.ei   = ei[3:0]; v.eg = eg[3:0]; v.epp = pp[3:0]; v.epm = pm[3:0];
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    bus.pred_pc        = v.pc;
    bus.pred_valid     = v.pv;
    bus.stall          = v.st;
    bus.upd_valid      = v.uv;
    bus.upd_mispredict = v.um;
    bus.upd_taken      = v.ut;
    bus.upd_idx        = v.uidx;
    bus.upd_ghr        = v.ughr;
  endtask

  task automatic idle();
    bus.pred_pc = 32'h0; bus.pred_valid = 1'b0; bus.stall = 1'b0;
    bus.upd_valid = 1'b0; bus.upd_mispredict = 1'b0; bus.upd_taken = 1'b0;
    bus.upd_idx = '0; bus.upd_ghr = '0;
  endtask

  task automatic chk_outputs(input string nm, input exp_t e);
    chk({nm, " taken"}, 32'(bus.pred_taken), 32'(e.et));
    chk({nm, " idx"},   32'(bus.pred_idx),   32'(e.ei));
    chk({nm, " ghr"},   32'(bus.pred_ghr),   32'(e.eg));
    chk({nm, " pperf"}, 32'(bus.perf_pred),  32'(e.epp));
    chk({nm, " mperf"}, 32'(bus.perf_miss),  32'(e.epm));
  endtask

  initial begin
    exp_t e;
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst = 1'b1;

    // Reset sweep: stalled predictions, every index reads weakly-not-taken.
    for (int i = 0; i < 16; i++) add(4*i, 1, 1, 0, 0, 0, 0, 0, 0, i, 0, 0, 0);
    // Saturation at idx 5: up three times, down four times.
    add('h14, 0, 0, 1, 0, 1, 5, 0, 0, 5, 0, 0, 0);
    add('h14, 0, 0, 1, 0, 1, 5, 0, 1, 5, 0, 0, 0);
    add('h14, 0, 0, 1, 0, 1, 5, 0, 1, 5, 0, 0, 0);
    add('h14, 0, 0, 1, 0, 0, 5, 0, 1, 5, 0, 0, 0);
    add('h14, 0, 0, 1, 0, 0, 5, 0, 1, 5, 0, 0, 0);
    add('h14, 0, 0, 1, 0, 0, 5, 0, 0, 5, 0, 0, 0);
    add('h14, 0, 0, 1, 0, 0, 5, 0, 0, 5, 0, 0, 0);
    add('h14, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    // Train idx 1 strongly taken, then predict 1,0,1 -> ghr 0101, hash check.
    add('h00, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add('h00, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add('h04, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add('h0C, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
    add('h0C, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 0);
    add('h20, 0, 0, 0, 0, 0, 0, 0, 0, 13, 5, 3, 0);
    // Stall freeze.
    for (int i = 0; i < 5; i++) add('h0C, 1, 1, 0, 0, 0, 0, 0, 0, 6, 5, 3, 0);
    add('h20, 0, 0, 0, 0, 0, 0, 0, 0, 13, 5, 3, 0);
    // Three taken predictions through idx 1 -> ghr 1111.
    add('h10, 1, 0, 0, 0, 0, 0, 0, 1, 1, 5, 3, 0);
    add('h28, 1, 0, 0, 0, 0, 0, 0, 1, 1, 11, 4, 0);
    add('h18, 1, 0, 0, 0, 0, 0, 0, 1, 1, 7, 5, 0);
    // Recovery colliding with a prediction: ghr <- {010,1}.
    add('h00, 1, 0, 1, 1, 1, 7, 2, 0, 15, 15, 6, 0);
    add('h20, 0, 0, 0, 0, 0, 0, 0, 0, 13, 5, 6, 1);
    // Recovery under stall: ghr <- {011,0}.
    add('h20, 1, 1, 1, 1, 0, 7, 3, 0, 13, 5, 6, 1);
    add('h20, 0, 0, 0, 0, 0, 0, 0, 0, 14, 6, 6, 2);
    // Correct-prediction update leaves history alone.
    add('h20, 0, 0, 1, 0, 1, 7, 15, 0, 14, 6, 6, 2);
    // Read-before-write at idx 3.
    add('h14, 0, 0, 1, 0, 1, 3, 0, 0, 3, 6, 6, 2);
    add('h14, 0, 0, 0, 0, 0, 0, 0, 1, 3, 6, 6, 2);

    // Outputs while held in reset, even with an unstalled prediction presented.
    bus.pred_pc = 32'h24; bus.pred_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    e = '{et: 1'b0, ei: 4'd9, eg: 4'd0, epp: 4'd0, epm: 4'd0};
    chk_outputs("in_reset", e);
    idle();
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      exp_q.push_back('{et: vecs[i].et, ei: vecs[i].ei, eg: vecs[i].eg,
                        epp: vecs[i].epp, epm: vecs[i].epm});
      @(negedge clk);
      e = exp_q.pop_front();
      chk_outputs($sformatf("v%0d", i), e);
      @(posedge clk); #1;
    end

    // perf_pred saturates: 6 + 12 predictions clamp at 15.
    idle();
    for (int i = 0; i < 12; i++) begin
      bus.pred_valid = 1'b1;
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    chk("perf_pred_sat", 32'(bus.perf_pred), 32'd15);

    // perf_miss saturates: 2 + 16 mispredicts clamp at 15; final ghr = {000,1}.
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      bus.upd_valid = 1'b1; bus.upd_mispredict = 1'b1; bus.upd_taken = 1'b1;
      bus.upd_idx = 4'd7; bus.upd_ghr = 4'd0;
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    chk("perf_miss_sat",  32'(bus.perf_miss),  32'd15);
    chk("perf_pred_hold", 32'(bus.perf_pred),  32'd15);
    chk("pre_rst_ghr",    32'(bus.pred_ghr),   32'd1);
    chk("pre_rst_taken",  32'(bus.pred_taken), 32'd1);

    // Reset pulse between edges clears everything before the next edge.
    #2 rst = 1'b1;
    #1;
    chk("arst_taken", 32'(bus.pred_taken), 32'd0);
    chk("arst_idx",   32'(bus.pred_idx),   32'd0);
    chk("arst_ghr",   32'(bus.pred_ghr),   32'd0);
    chk("arst_pperf", 32'(bus.perf_pred),  32'd0);
    chk("arst_mperf", 32'(bus.perf_miss),  32'd0);
    #1 rst = 1'b0;
    bus.pred_pc = 32'h04;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_taken", 32'(bus.pred_taken), 32'd0);
    chk("post_rst_idx",   32'(bus.pred_idx),   32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised global-history (gshare) conditional-branch predictor for the fetch stage, the successor to the fixed single-path B-type prediction logic. It predicts taken/not-taken in the same cycle as fetch by XORing PC bits with a speculative global history register (GHR). It trains a table of saturating counters from branch resolution and restores the GHR from a per-branch snapshot on misprediction. It also keeps saturating performance counters for predictions and mispredictions.

## Interface
- ENTRIES, 256, counter-table depth; power of two, 4..4096; IDX_W = log2(ENTRIES)
- GHR_WIDTH, 8, global history length; 1..IDX_W
- CNT_WIDTH, 2, saturating-counter width; 1..4
- PC_LSB, 2, lowest PC bit used for indexing
- PERF_WIDTH, 32, width of performance counters
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- pred_valid  input  1  fetched instruction is a conditional branch
- pred_pc  input  32  PC of fetched instruction
- stall  input  1  pipeline stall; blocks GHR shift and perf counting
- pred_taken  output  1  prediction: MSB of indexed counter (combinational)
- pred_idx  output  IDX_W  table index used (carried down pipeline)
- pred_ghr  output  GHR_WIDTH  GHR value before this prediction (snapshot)
- upd_valid  input  1  a conditional branch resolved this cycle
- upd_idx  input  IDX_W  pred_idx carried with the resolving branch
- upd_ghr  input  GHR_WIDTH  pred_ghr carried with the resolving branch
- upd_taken  input  1  actual outcome
- upd_mispredict  input  1  outcome differed from prediction; qualified by upd_valid
- perf_pred  output  PERF_WIDTH  count of accepted predictions
- perf_miss  output  PERF_WIDTH  count of mispredictions

## Operation
- Index: pred_idx = pred_pc[PC_LSB +: IDX_W] XOR {zeros, ghr}.
- Outputs pred_taken, pred_idx, and pred_ghr are valid every cycle; consumers qualify them with pred_valid.
- Counter table: ENTRIES × CNT_WIDTH flops. Reset value of every entry is weakly-not-taken, i.e. 2^(CNT_WIDTH-1)-1. For CNT_WIDTH=1 the reset value is 0.
- Training: on upd_valid, the counter at upd_idx increments if upd_taken and decrements otherwise. It saturates at all-ones and at zero; it never wraps.
- Speculative GHR update: on pred_valid && !stall, ghr <= {ghr[GHR_WIDTH-2:0], pred_taken}. For GHR_WIDTH=1, ghr <= pred_taken.
- Recovery: on upd_valid && upd_mispredict, ghr <= {upd_ghr[GHR_WIDTH-2:0], upd_taken}.
  - Recovery has priority over a same-cycle speculative shift; that fetch is being flushed.
  - Recovery is applied regardless of stall.
- Perf counters:
  - perf_pred increments on pred_valid && !stall && !(upd_valid && upd_mispredict).
  - perf_miss increments on upd_valid && upd_mispredict.
  - Both saturate at all-ones and are independent of each other.
- upd_valid with !upd_mispredict trains the table only; the GHR is untouched by the update path.

## Timing
- Prediction latency is 0 cycles: combinational from pred_pc and the registered GHR/table.
- A table write at edge N is visible to predictions from cycle N+1.
- Same-cycle read and write to the same index: the prediction uses the pre-update value (read-before-write).
- A GHR shift or recovery at edge N affects the index from cycle N+1.
- Reset values: ghr=0, all counters at weakly-not-taken, perf_pred=0, perf_miss=0.
  - Output pred_taken=0 during reset (any CNT_WIDTH).
  - pred_idx = pred_pc index bits during reset.
  - pred_ghr = 0 during reset.
- Reset asserted mid-operation clears all state immediately (asynchronous); updates in flight are discarded.
- There is no backpressure and no handshake: one prediction and one update per cycle maximum, both always accepted.

## Test plan
- Reset defaults (ENTRIES=16, GHR_WIDTH=4): assert rst, release, sweep pred_pc 0x00..0x3C step 4 with pred_valid=1, stall=1 -> pred_taken=0 everywhere, pred_idx = pc[5:2], pred_ghr=0, perf_pred stays 0.
- Saturation: 3 updates with upd_idx=5, upd_taken=1 -> counter 01→10→11→11; prediction at idx 5 goes taken after the first update. Then 4 not-taken updates -> counter reaches 00 and stays there.
- GHR shift and hashing: pred_valid on 3 consecutive unstalled cycles with predictions 1,0,1 -> ghr=4'b0101. Next pred_pc=0x20 -> pred_idx = 8 XOR 5 = 13.
- Stall freeze: hold stall=1 for 5 cycles with pred_valid=1 -> ghr and perf_pred unchanged.
- Misprediction recovery colliding with a prediction: ghr=4'b1111, same cycle pred_valid=1 and upd_valid=1, upd_mispredict=1, upd_ghr=4'b0010, upd_taken=1 -> next cycle ghr=4'b0101, perf_miss +1, perf_pred unchanged.
- Async reset and read-before-write: (1) Pulse rst between clock edges after training -> outputs return to reset values before the next edge. (2) Same-cycle read and update at idx 3 (counter 01, upd_taken=1) -> pred_taken=0 this cycle, 1 next cycle.
